// File: rtl/cd_sector_deframer.sv
// CD-ROM raw sector deframer: writes each sector into one half of a ping-pong buffer
// and extracts sync status, BCD header, subheader and the decoded LBA.
module cd_sector_deframer #(
  parameter int SECTOR_WORDS = 1188
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cd_data,
  input  logic        cd_data_valid,
  input  logic        sector_delivered,
  input  logic [31:0] expected_lba,
  output logic [11:0] buf_addr,
  output logic [15:0] buf_data,
  output logic        buf_we,
  output logic        sector_done,
  output logic        done_buf,
  output logic [7:0]  hdr_minute,
  output logic [7:0]  hdr_second,
  output logic [7:0]  hdr_frame,
  output logic [7:0]  hdr_mode,
  output logic [31:0] subhdr,
  output logic [31:0] sector_lba,
  output logic [4:0]  status
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SYNC    = 3'd1;
  localparam logic [2:0] ST_HEADER  = 3'd2;
  localparam logic [2:0] ST_SUBHDR  = 3'd3;
  localparam logic [2:0] ST_PAYLOAD = 3'd4;
  localparam logic [2:0] ST_SUBCH   = 3'd5;
  localparam logic [2:0] ST_FULL    = 3'd6;
  localparam logic [2:0] ST_DONE    = 3'd7;
  localparam logic [10:0] FULL_IDX  = 11'(SECTOR_WORDS);

  function automatic logic [7:0] bcd_to_bin(input logic [7:0] b);
    return 8'({4'd0, b[7:4]} * 8'd10 + {4'd0, b[3:0]});
  endfunction

  function automatic logic bcd_bad(input logic [7:0] b);
    return (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
  endfunction

  function automatic logic [15:0] sync_word(input logic [2:0] idx);
    case (idx)
      3'd0:    sync_word = 16'hFF00;
      3'd5:    sync_word = 16'h00FF;
      default: sync_word = 16'hFFFF;
    endcase
  endfunction

  // State that owns the word at a given index
  function automatic logic [2:0] state_for(input logic [10:0] idx);
    if (idx < 11'd6)         return ST_SYNC;
    else if (idx < 11'd8)    return ST_HEADER;
    else if (idx < 11'd10)   return ST_SUBHDR;
    else if (idx < 11'd1176) return ST_PAYLOAD;
    else if (idx < FULL_IDX) return ST_SUBCH;
    else                     return ST_FULL;
  endfunction

  logic [2:0]  state_r;
  logic [10:0] word_index_r;
  logic        buf_sel_r;
  logic [7:0]  min_r, sec_r, frm_r, mode_r;
  logic [31:0] subhdr_r;
  logic        sync_err_r, bcd_err_r, overrun_r;

  logic        accept_s, go_done_s;
  logic [10:0] index_next_s;
  logic [7:0]  min_s, sec_s, frm_s, mode_s;
  logic [31:0] subhdr_s, lba_s;
  logic        sync_err_s, bcd_err_s, overrun_s;

  // Word acceptance, end-of-sector detection and next accumulator values
  always_comb begin
    accept_s     = 1'b0;
    case (state_r)
      ST_IDLE, ST_SYNC, ST_HEADER, ST_SUBHDR, ST_PAYLOAD, ST_SUBCH: accept_s = cd_data_valid;
      default: accept_s = 1'b0;
    endcase
    index_next_s = accept_s ? word_index_r + 11'd1 : word_index_r;
    go_done_s    = sector_delivered && (state_r != ST_DONE) && ((state_r != ST_IDLE) || accept_s);

    min_s = min_r;  sec_s = sec_r;  frm_s = frm_r;  mode_s = mode_r;
    subhdr_s = subhdr_r;  sync_err_s = sync_err_r;  bcd_err_s = bcd_err_r;  overrun_s = overrun_r;
    // Leaving IDLE starts a fresh sector, so accumulators start from zero
    if (state_r == ST_IDLE) begin
      min_s = 8'd0;  sec_s = 8'd0;  frm_s = 8'd0;  mode_s = 8'd0;
      subhdr_s = 32'd0;  sync_err_s = 1'b0;  bcd_err_s = 1'b0;  overrun_s = 1'b0;
    end else begin
      overrun_s = overrun_r | ((state_r == ST_FULL) && cd_data_valid);
    end

    if (accept_s) begin
      case (word_index_r)
        11'd6: begin
          min_s = cd_data[7:0];
          sec_s = cd_data[15:8];
          bcd_err_s = bcd_err_s | bcd_bad(cd_data[7:0]) | bcd_bad(cd_data[15:8]);
        end
        11'd7: begin
          frm_s  = cd_data[7:0];
          mode_s = cd_data[15:8];
          bcd_err_s = bcd_err_s | bcd_bad(cd_data[7:0]);
        end
        11'd8:   subhdr_s[15:0]  = cd_data;
        11'd9:   subhdr_s[31:16] = cd_data;
        default: subhdr_s = subhdr_s;
      endcase
      if ((word_index_r < 11'd6) && (cd_data != sync_word(word_index_r[2:0]))) begin
        sync_err_s = 1'b1;
      end else begin
        sync_err_s = sync_err_s;
      end
    end else begin
      sync_err_s = sync_err_s;
    end

    lba_s = ({24'd0, bcd_to_bin(min_s)} * 32'd60 + {24'd0, bcd_to_bin(sec_s)}) * 32'd75
            + {24'd0, bcd_to_bin(frm_s)} - 32'd150;
  end

  // Sequencing, buffer writes and completion outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;  word_index_r <= 11'd0;  buf_sel_r <= 1'b0;
      min_r <= 8'd0;  sec_r <= 8'd0;  frm_r <= 8'd0;  mode_r <= 8'd0;  subhdr_r <= 32'd0;
      sync_err_r <= 1'b0;  bcd_err_r <= 1'b0;  overrun_r <= 1'b0;
      buf_addr <= 12'd0;  buf_data <= 16'd0;  buf_we <= 1'b0;
      sector_done <= 1'b0;  done_buf <= 1'b0;
      hdr_minute <= 8'd0;  hdr_second <= 8'd0;  hdr_frame <= 8'd0;  hdr_mode <= 8'd0;
      subhdr <= 32'd0;  sector_lba <= 32'd0;  status <= 5'd0;
    end else begin
      buf_we      <= 1'b0;
      sector_done <= 1'b0;
      min_r <= min_s;  sec_r <= sec_s;  frm_r <= frm_s;  mode_r <= mode_s;  subhdr_r <= subhdr_s;
      sync_err_r <= sync_err_s;  bcd_err_r <= bcd_err_s;  overrun_r <= overrun_s;
      word_index_r <= index_next_s;
      if (accept_s) begin
        buf_we   <= 1'b1;
        buf_addr <= {buf_sel_r, word_index_r};
        buf_data <= cd_data;
      end
      if (state_r == ST_DONE) begin
        state_r      <= ST_IDLE;
        word_index_r <= 11'd0;
        buf_sel_r    <= ~buf_sel_r;
      end else if (go_done_s) begin
        state_r     <= ST_DONE;
        sector_done <= 1'b1;
        done_buf    <= buf_sel_r;
        hdr_minute  <= min_s;
        hdr_second  <= sec_s;
        hdr_frame   <= frm_s;
        hdr_mode    <= mode_s;
        subhdr      <= subhdr_s;
        sector_lba  <= lba_s;
        status      <= {overrun_s, (index_next_s < FULL_IDX), bcd_err_s,
                        (lba_s != expected_lba), sync_err_s};
      end else if (accept_s) begin
        state_r <= state_for(index_next_s);
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule

// File: tb/tb_cd_sector_deframer.sv
// Randomized directed bench for cd_sector_deframer against a sector-level reference model.
module tb_cd_sector_deframer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cd_data = 16'd0;
  logic        cd_data_valid = 1'b0;
  logic        sector_delivered = 1'b0;
  logic [31:0] expected_lba = 32'd0;
  logic [11:0] buf_addr;
  logic [15:0] buf_data;
  logic        buf_we, sector_done, done_buf;
  logic [7:0]  hdr_minute, hdr_second, hdr_frame, hdr_mode;
  logic [31:0] subhdr, sector_lba;
  logic [4:0]  status;

  cd_sector_deframer #(.SECTOR_WORDS(1188)) dut (
    .clk(clk), .reset_n(reset_n), .cd_data(cd_data), .cd_data_valid(cd_data_valid),
    .sector_delivered(sector_delivered), .expected_lba(expected_lba),
    .buf_addr(buf_addr), .buf_data(buf_data), .buf_we(buf_we),
    .sector_done(sector_done), .done_buf(done_buf),
    .hdr_minute(hdr_minute), .hdr_second(hdr_second), .hdr_frame(hdr_frame), .hdr_mode(hdr_mode),
    .subhdr(subhdr), .sector_lba(sector_lba), .status(status)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Observed activity, captured away from the active edge
  logic [27:0] obs_wr[$];
  int          done_cnt = 0;
  logic        snap_buf = 1'b0;
  logic [4:0]  snap_status = 5'd0;
  logic [31:0] snap_lba = 32'd0, snap_sub = 32'd0;
  logic [7:0]  snap_min = 8'd0, snap_sec = 8'd0, snap_frm = 8'd0, snap_mode = 8'd0;

  always @(negedge clk) begin
    if (buf_we) obs_wr.push_back({buf_addr, buf_data});
    if (sector_done) begin
      done_cnt    <= done_cnt + 1;
      snap_buf    <= done_buf;
      snap_status <= status;
      snap_lba    <= sector_lba;
      snap_sub    <= subhdr;
      snap_min    <= hdr_minute;
      snap_sec    <= hdr_second;
      snap_frm    <= hdr_frame;
      snap_mode   <= hdr_mode;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd_val(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [31:0] model_lba(input logic [7:0] m, input logic [7:0] s, input logic [7:0] f);
    int v;
    v = (bcd_val(m) * 60 + bcd_val(s)) * 75 + bcd_val(f) - 150;
    return 32'(v);
  endfunction

  function automatic bit bad_bcd(input logic [7:0] b);
    return (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
  endfunction

  function automatic logic [7:0] rand_bcd(input int max_tens);
    logic [7:0] r;
    r[7:4] = 4'($urandom_range(0, max_tens));
    r[3:0] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  logic        exp_buf = 1'b0;
  logic [15:0] words[$];

  task automatic send_word(input logic [15:0] w);
    @(posedge clk); #1;
    cd_data = w;
    cd_data_valid = 1'b1;
    @(posedge clk); #1;
    cd_data_valid = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic deliver(input int exp_done, input string tag);
    int base;
    base = done_cnt;
    @(posedge clk); #1;
    sector_delivered = 1'b1;
    @(posedge clk); #1;
    sector_delivered = 1'b0;
    for (int c = 0; c < 20 && done_cnt == base; c++) @(posedge clk);
    repeat (4) @(posedge clk);
    check({tag, "_done_cnt"}, 64'(done_cnt - base), 64'(exp_done));
  endtask

  // Build a sector, stream it, optionally deliver it, and check it against the model
  task automatic run_sector(input string tag, input logic [7:0] m, input logic [7:0] s,
                            input logic [7:0] f, input logic [7:0] md, input logic [31:0] sub,
                            input int n, input int bad_sync_idx, input logic [31:0] exp_lba,
                            input bit do_deliver);
    logic [15:0] sync_tbl[6];
    logic [31:0] lba;
    logic [4:0]  st;
    logic [27:0] first_w, last_w;
    int nw, bad;
    sync_tbl = '{16'hFF00, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h00FF};
    words.delete();
    for (int i = 0; i < n; i++) begin
      if (i < 6)       words.push_back(sync_tbl[i]);
      else if (i == 6) words.push_back({s, m});
      else if (i == 7) words.push_back({md, f});
      else if (i == 8) words.push_back(sub[15:0]);
      else if (i == 9) words.push_back(sub[31:16]);
      else             words.push_back(16'($urandom));
    end
    if (bad_sync_idx >= 0) words[bad_sync_idx] = 16'hFEFF;
    expected_lba = exp_lba;
    obs_wr.delete();
    for (int i = 0; i < n; i++) send_word(words[i]);
    if (!do_deliver) return;
    deliver(1, tag);

    nw  = (n < 1188) ? n : 1188;
    lba = model_lba(m, s, f);
    st  = {n > 1188, n < 1188, bad_bcd(m) || bad_bcd(s) || bad_bcd(f), lba != exp_lba,
           bad_sync_idx >= 0};
    check({tag, "_wr_count"}, 64'(obs_wr.size()), 64'(nw));
    bad = 0;
    for (int i = 0; i < obs_wr.size() && i < nw; i++)
      if (obs_wr[i] !== {exp_buf, 11'(i), words[i]}) bad++;
    check({tag, "_wr_content"}, 64'(bad), 64'd0);
    first_w = (obs_wr.size() > 0) ? obs_wr[0] : 28'hFFFFFFF;
    last_w  = (obs_wr.size() > 0) ? obs_wr[obs_wr.size() - 1] : 28'hFFFFFFF;
    check({tag, "_first_addr"}, 64'(first_w[27:16]), 64'({exp_buf, 11'd0}));
    check({tag, "_last_addr"}, 64'(last_w[27:16]), 64'({exp_buf, 11'(nw - 1)}));
    check({tag, "_done_buf"}, 64'(snap_buf), 64'(exp_buf));
    check({tag, "_status"}, 64'(snap_status), 64'(st));
    check({tag, "_lba"}, 64'(snap_lba), 64'(lba));
    check({tag, "_hdr"}, {32'd0, snap_min, snap_sec, snap_frm, snap_mode}, {32'd0, m, s, f, md});
    check({tag, "_subhdr"}, 64'(snap_sub), 64'(sub));
    exp_buf = ~exp_buf;
  endtask

  initial begin
    logic [7:0] m, s, f;
    int base;
    #3;
    check("reset_outputs", {buf_we, sector_done, done_buf, status, buf_addr, buf_data},
          64'd0);
    check("reset_hdr", {sector_lba, hdr_minute, hdr_second, hdr_frame, hdr_mode}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Clean sectors at 00:02:00 and 00:02:01 fill buffer halves 0 and 1
    run_sector("clean0", 8'h00, 8'h02, 8'h00, 8'h02, $urandom, 1188, -1, 32'd0, 1'b1);
    run_sector("clean1", 8'h00, 8'h02, 8'h01, 8'h02, $urandom, 1188, -1, 32'd1, 1'b1);

    m = rand_bcd(7); s = rand_bcd(5); f = rand_bcd(6);
    run_sector("sync_err", m, s, f, 8'h02, $urandom, 1188, 3, model_lba(m, s, f), 1'b1);

    // Delivery with no accepted words must be ignored
    deliver(0, "idle_deliver");

    run_sector("bcd_short", 8'h1A, 8'h00, 8'h00, 8'h02, $urandom, 1000, -1, $urandom, 1'b1);

    m = rand_bcd(7); s = rand_bcd(5); f = rand_bcd(6);
    run_sector("overrun", m, s, f, 8'h01, $urandom, 1190, -1, model_lba(m, s, f), 1'b1);

    // Partial sector aborted by reset leaves no trace
    base = done_cnt;
    run_sector("partial", 8'h00, 8'h02, 8'h00, 8'h02, $urandom, 500, -1, 32'd0, 1'b0);
    @(posedge clk); #1 reset_n = 1'b0;
    #2 check("midreset_outputs", {buf_we, sector_done, done_buf, status}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    exp_buf = 1'b0;
    repeat (2) @(posedge clk);
    m = rand_bcd(7); s = rand_bcd(5); f = rand_bcd(6);
    run_sector("after_reset", m, s, f, 8'h02, $urandom, 1188, -1, model_lba(m, s, f), 1'b1);
    check("partial_no_done", 64'(done_cnt - base), 64'd1);

    m = rand_bcd(9); s = rand_bcd(5); f = rand_bcd(7);
    run_sector("mismatch", m, s, f, 8'h02, $urandom, 1188, -1, model_lba(m, s, f) + 32'd7, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cd_sector_deframer.md
CD_SECTOR_DEFRAMER -- requirements
Module: cd_sector_deframer

Interface
REQ-001 SECTOR_WORDS, default 1188, words per sector: 1176 (0x930 bytes) of sector data plus 12 of subchannel.
REQ-002 clk  input  1  single clock; all logic on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 cd_data  input  16  sector word from the upstream sector cache; byte N in [7:0], byte N+1 in [15:8].
REQ-005 cd_data_valid  input  1  one-clock strobe per word; at least 3 idle clocks between strobes.
REQ-006 sector_delivered  input  1  one-clock pulse after the last word of a sector.
REQ-007 expected_lba  input  32  LBA the consumer expects for the current sector.
REQ-008 buf_addr  output  12  sector buffer write address, {buf_sel, word_index[10:0]}.
REQ-009 buf_data  output  16  sector buffer write data.
REQ-010 buf_we  output  1  sector buffer write enable.
REQ-011 sector_done  output  1  one-clock pulse; header and status outputs are valid from this pulse.
REQ-012 done_buf  output  1  buffer half that holds the completed sector.
REQ-013 hdr_minute, hdr_second, hdr_frame, hdr_mode  output  8 each  raw header bytes 12..15.
REQ-014 subhdr  output  32  bytes 16..19 {coding, submode, channel, file}.
REQ-015 sector_lba  output  32  binary LBA decoded from the BCD header.
REQ-016 status  output  5  {overrun, short, bcd_err, lba_mismatch, sync_err}.

Function
REQ-017 States: IDLE, SYNC (words 0-5), HEADER (6-7), SUBHDR (8-9), PAYLOAD (10-1175), SUBCH (1176..SECTOR_WORDS-1), FULL, DONE.
REQ-018 An 11-bit word_index counts accepted words; it resets to 0 on entry to IDLE.
REQ-019 IDLE -> SYNC on the first cd_data_valid; that word is accepted as index 0.
REQ-020 Each accepted word advances the state at the index boundaries in REQ-017; index SECTOR_WORDS-1 -> FULL.
REQ-021 Any state except IDLE -> DONE on sector_delivered; DONE -> IDLE after one clock.
REQ-022 If cd_data_valid and sector_delivered coincide, the word is accepted first, then DONE is entered.
REQ-023 Each accepted word is written with latency 1: buf_we=1 for one clock, buf_addr={buf_sel, index}, buf_data=cd_data.
REQ-024 In FULL, words are not written; status.overrun is set.
REQ-025 Sync check: expected words are 0xFF00, 0xFFFF, 0xFFFF, 0xFFFF, 0xFFFF, 0x00FF; any mismatch sets sync_err.
REQ-026 Word 6 gives minute=[7:0] and second=[15:8]; word 7 gives frame=[7:0] and mode=[15:8].
REQ-027 Words 8-9 form subhdr, with word 8 in bits [15:0].
REQ-028 Any header BCD nibble greater than 9 sets bcd_err.
REQ-029 sector_lba = (min*60+sec)*75+frame-150, computed from BCD-decoded values modulo 2^32.
REQ-030 sector_lba is ready before DONE; a multi-cycle computation is allowed within the 4-clock word spacing.
REQ-031 lba_mismatch = (sector_lba != expected_lba), evaluated when DONE is entered.
REQ-032 short is set when sector_delivered arrives with word_index < SECTOR_WORDS.
REQ-033 In DONE: sector_done=1, done_buf=buf_sel, and the status and header outputs are updated.
REQ-034 Status and header outputs hold their values until the next DONE.
REQ-035 buf_sel toggles at the end of DONE, so consecutive sectors alternate buffer halves.
REQ-036 Internal status accumulators clear on entry to SYNC.
REQ-037 sector_delivered while in IDLE (zero words accepted) is ignored: no sector_done pulse and no buf_sel toggle.

Reset
REQ-038 When reset_n is low, all state clears asynchronously: state=IDLE, word_index=0, buf_sel=0.
REQ-039 Reset values: buf_we=0, buf_addr=0, buf_data=0, sector_done=0, done_buf=0, all header outputs, subhdr, sector_lba and status 0.
REQ-040 Reset mid-sector discards the partial sector: no sector_done and no further writes for it.
REQ-041 After reset the next cd_data_valid starts a new sector at index 0.

Verification
REQ-042 Clean sector, header 00:02:00 mode 02, expected_lba=0, 1188 words, then sector_delivered -> 1188 writes at 0x000-0x4A3; sector_done with done_buf=0, sector_lba=0, status=0.
REQ-043 Second clean sector, header 00:02:01 -> writes to 0x800-0xCA3; sector_lba=1; done_buf=1.
REQ-044 Word 3 = 0xFEFF -> status=00001 (sync_err only); all 1188 words still written.
REQ-045 Header 0x1A:00:00 with 1000 words, then sector_delivered -> bcd_err=1, short=1; sector_done asserted.
REQ-046 1190 words before sector_delivered -> last two words not written; overrun=1.
REQ-047 reset_n low after 500 words, then a full clean sector -> one sector_done only, with done_buf=0 and writes starting at 0x000.
